// File: rtl/tdm_pkg.sv
// Shared types and constants for the TDM demultiplexer and its slot counter.
package tdm_pkg;

    localparam int NCH    = 8;
    localparam int SLOT_W = 3;

    typedef enum logic {HUNT, LOCK} tdm_state_t;

    typedef logic [SLOT_W-1:0] slot_t;

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot counter for 8-slot TDM framing; shared by the receive demux and the transmit framer.
// load0 marks the current sample as slot 0, so the next sample goes to slot 1.
module tdm_slot_ctr
    import tdm_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  inc,
    input  logic  load0,
    output slot_t slot,
    output logic  wrap
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot <= '0;
        end else if (load0) begin
            slot <= slot_t'(1);
        end else if (inc) begin
            slot <= slot + slot_t'(1);
        end
    end

    assign wrap = inc & (slot == slot_t'(NCH - 1));

endmodule

// File: rtl/tdm_demux8.sv
// 1:8 TDM demultiplexer: aligns on in_sync, gathers 8 slot samples, publishes them as one frame.
// Optional build macro TDM_DEMUX_SYNC_ERR_EN adds a misaligned-sync pulse and saturating counter.
module tdm_demux8
    import tdm_pkg::*;
#(
    parameter int W = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    input  logic           in_sync,
    input  logic [W-1:0]   in_data,
    output logic [NCH*W-1:0] ch_data,
    output logic           frame_valid,
    output logic           locked,
    output slot_t          slot
`ifdef TDM_DEMUX_SYNC_ERR_EN
    ,
    output logic           sync_err,
    output logic [7:0]     sync_err_cnt
`endif
);

    tdm_state_t   state;
    logic         take_sync;
    logic         take_data;
    logic         wrap;
    logic         misalign;
    slot_t        wr_slot;

    // Slot 7 never lands in a shadow register; it goes straight into the published frame.
    logic [W-1:0] shadow [NCH-1];

    assign take_sync = in_valid & in_sync;
    assign take_data = in_valid & ~in_sync & (state == LOCK);
    assign misalign  = take_sync & (state == LOCK) & (slot != '0);
    assign wr_slot   = take_sync ? slot_t'(0) : slot;

    tdm_slot_ctr u_slot_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (take_data),
        .load0 (take_sync),
        .slot  (slot),
        .wrap  (wrap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= HUNT;
            locked <= 1'b0;
        end else begin
            case (state)
                HUNT: begin
                    if (take_sync) begin
                        state  <= LOCK;
                        locked <= 1'b1;
                    end
                end
                LOCK: begin
                    state  <= LOCK;
                    locked <= 1'b1;
                end
                default: begin
                    state  <= HUNT;
                    locked <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: the shadow array is small and must read as zero after reset, so it is reset like any flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NCH - 1; k++) begin
                shadow[k] <= '0;
            end
        end else if ((take_sync || take_data) && !wrap) begin
            shadow[wr_slot] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_data     <= '0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= wrap;
            if (wrap) begin
                for (int k = 0; k < NCH - 1; k++) begin
                    ch_data[k*W +: W] <= shadow[k];
                end
                ch_data[(NCH-1)*W +: W] <= in_data;
            end
        end
    end

`ifdef TDM_DEMUX_SYNC_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_err     <= 1'b0;
            sync_err_cnt <= '0;
        end else begin
            sync_err <= misalign;
            if (misalign && (sync_err_cnt != 8'hFF)) begin
                sync_err_cnt <= sync_err_cnt + 8'd1;
            end
        end
    end
`else
    logic unused_misalign;
    assign unused_misalign = misalign;
`endif

endmodule
